// File: rtl/frame_loader.sv
// Framed byte loader: hunts for a sync byte, writes NUM_WORDS*4 payload bytes
// into a word buffer, then checks a modulo-256 additive checksum.
module frame_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned NUM_WORDS      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       receiving,
  output logic [1:0] byte_offset,
  output logic [4:0] word_offset,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned TW = 16;
  localparam int unsigned WW = 5;
  localparam int unsigned BW = 2;
  localparam int unsigned DW = 8;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  byte_ptr_q, byte_ptr_d;
  logic [WW-1:0]  word_ptr_q, word_ptr_d;
  logic [DW-1:0]  csum_q, csum_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           receiving_q, receiving_d;
  logic [DW-1:0]  data_q, data_d;
  logic [BW-1:0]  boff_q, boff_d;
  logic [WW-1:0]  woff_q, woff_d;
  logic           busy_q;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           tmo_hit_c;

  assign tmo_hit_c = (tmo_q == TMO_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_ptr_q  <= '0;
      word_ptr_q  <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      receiving_q <= 1'b0;
      data_q      <= '0;
      boff_q      <= '0;
      woff_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_ptr_q  <= byte_ptr_d;
      word_ptr_q  <= word_ptr_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      receiving_q <= receiving_d;
      data_q      <= data_d;
      boff_q      <= boff_d;
      woff_q      <= woff_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    byte_ptr_d  = byte_ptr_q;
    word_ptr_d  = word_ptr_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    receiving_d = 1'b0;
    data_d      = data_q;
    boff_d      = boff_q;
    woff_d      = woff_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d    = LOAD;
          byte_ptr_d = '0;
          word_ptr_d = '0;
          csum_d     = '0;
          tmo_d      = '0;
        end
      end

      LOAD: begin
        // A received byte always wins over an expiring timeout
        if (rx_valid) begin
          tmo_d       = '0;
          receiving_d = 1'b1;
          data_d      = rx_data;
          boff_d      = byte_ptr_q;
          woff_d      = word_ptr_q;
          csum_d      = csum_q + rx_data;
          byte_ptr_d  = byte_ptr_q + BW'(1);
          if (byte_ptr_q == BW'(3)) begin
            word_ptr_d = word_ptr_q + WW'(1);
            if (word_ptr_q == WORD_LAST) begin
              state_d = CHECK;
            end
          end
        end else if (tmo_hit_c) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      CHECK: begin
        if (rx_valid) begin
          tmo_d   = '0;
          state_d = IDLE;
          if (rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_hit_c) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign receiving   = receiving_q;
  assign byte_offset = boff_q;
  assign word_offset = woff_q;
  assign data_out    = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: a byte-level model queues expected
// buffer writes and frame results; a negedge monitor pops and compares them.
module tb_frame_loader;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned NW   = 20;
  localparam int unsigned NB   = 4 * NW;
  localparam int unsigned TMO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       receiving;
  logic [1:0] byte_offset;
  logic [4:0] word_offset;
  logic [7:0] data_out;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  frame_loader #(
    .SYNC_BYTE      (SYNC),
    .NUM_WORDS      (NW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .receiving   (receiving),
    .byte_offset (byte_offset),
    .word_offset (word_offset),
    .data_out    (data_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected writes {word, lane, data} and results {done, err}
  logic [14:0] exp_wr[$];
  logic [1:0]  exp_res[$];

  int cyc = 0;
  int last_wr_cyc = 0;
  int res_cyc = 0;
  int n_done = 0;
  int n_err = 0;
  logic [14:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (receiving) begin
      last_wr_cyc = cyc;
      if (exp_wr.size() == 0) begin
        chk("spurious_wr", {17'd0, word_offset, byte_offset, data_out}, 32'hFFFF);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr", {17'd0, word_offset, byte_offset, data_out}, {17'd0, mon_e});
      end
    end
    if (frame_done || frame_err) begin
      res_cyc = cyc;
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
      chk("done_err_excl", 32'(frame_done & frame_err), 32'd0);
      chk("res_no_wr", 32'(receiving), 32'd0);
      chk("res_busy", 32'(busy), 32'd0);
      if (exp_res.size() == 0) begin
        chk("spurious_res", {30'd0, frame_done, frame_err}, 32'd0);
      end else begin
        chk("result", {30'd0, frame_done, frame_err}, {30'd0, exp_res.pop_front()});
      end
    end
  end

  // Reference model of the loader, advanced once per driven byte
  int         m_state = 0;
  logic [1:0] m_b = '0;
  logic [4:0] m_w = '0;
  logic [7:0] m_cs = '0;
  logic [7:0] pay [NB];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    case (m_state)
      0: if (b == SYNC) begin
        m_state = 1; m_b = '0; m_w = '0; m_cs = '0;
      end
      1: begin
        exp_wr.push_back({m_w, m_b, b});
        m_cs = m_cs + b;
        if (m_b == 2'd3) begin
          if (m_w == 5'(NW - 1)) m_state = 2;
          m_w = m_w + 5'd1;
        end
        m_b = m_b + 2'd1;
      end
      default: begin
        exp_res.push_back((b == m_cs) ? 2'b10 : 2'b01);
        m_state = 0;
      end
    endcase
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] cs_xor, input int gap_idx, input int gap_len);
    send(SYNC);
    for (int i = 0; i < int'(NB); i++) begin
      if (i == gap_idx) idle(gap_len);
      send(pay[i]);
    end
    if (gap_idx == int'(NB)) idle(gap_len);
    send(m_cs ^ cs_xor);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    repeat (2) @(negedge clk);
    while ((exp_wr.size() != 0 || exp_res.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(exp_wr.size() + exp_res.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int exp_done = 0;
  int exp_err = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(3);
    chk("rst_receiving", 32'(receiving), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_boff", 32'(byte_offset), 32'd0);
    chk("rst_woff", 32'(word_offset), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    rst = 1'b0;
    idle(2);

    // Non-sync bytes in IDLE are ignored; sync starts the frame
    send(8'h11);
    chk("idle_busy_11", 32'(busy), 32'd0);
    send(8'h22);
    chk("idle_busy_22", 32'(busy), 32'd0);
    send(SYNC);
    chk("sync_busy", 32'(busy), 32'd1);
    for (int i = 0; i < int'(NB); i++) pay[i] = 8'(i);
    for (int i = 0; i < int'(NB); i++) send(pay[i]);
    chk("ramp_csum", 32'(m_cs), 32'h58);
    send(m_cs);
    exp_done++;
    drain("ramp_good_drain");
    chk("ramp_good_done", 32'(n_done), 32'(exp_done));
    chk("ramp_good_busy", 32'(busy), 32'd0);
    chk("hold_data", 32'(data_out), 32'h4F);
    chk("hold_woff", 32'(word_offset), 32'(NW - 1));
    chk("hold_boff", 32'(byte_offset), 32'd3);

    // Same frame, checksum off by one
    send_frame(8'h00 ^ 8'h00, -1, 0);
    exp_done++;
    drain("ramp_repeat_drain");
    send(SYNC);
    for (int i = 0; i < int'(NB); i++) send(pay[i]);
    send(m_cs + 8'd1);
    exp_err++;
    drain("ramp_bad_drain");
    chk("ramp_bad_err", 32'(n_err), 32'(exp_err));
    chk("ramp_bad_done", 32'(n_done), 32'(exp_done));

    // Timeout after sync plus five payload bytes
    send(SYNC);
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
    m_state = 0;
    exp_res.push_back(2'b01);
    exp_err++;
    drain("tmo_drain");
    chk("tmo_err", 32'(n_err), 32'(exp_err));
    chk("tmo_latency", 32'(res_cyc - last_wr_cyc), 32'(TMO));
    chk("tmo_woff", 32'(word_offset), 32'd1);
    chk("tmo_boff", 32'(byte_offset), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Bytes arriving exactly on the timeout boundary are accepted
    for (int i = 0; i < int'(NB); i++) pay[i] = 8'($urandom);
    send_frame(8'h00, 37, TMO - 1);
    exp_done++;
    drain("edge_mid_drain");
    send_frame(8'h00, int'(NB), TMO - 1);
    exp_done++;
    drain("edge_csum_drain");
    chk("edge_done", 32'(n_done), 32'(exp_done));
    chk("edge_err", 32'(n_err), 32'(exp_err));

    // Reset mid-frame aborts silently
    send(SYNC);
    for (int i = 0; i < 40; i++) send(pay[i]);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_receiving", 32'(receiving), 32'd0);
    chk("mid_rst_woff", 32'(word_offset), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    rst = 1'b0;
    m_state = 0;
    chk("mid_rst_pending", 32'(exp_wr.size()), 32'd0);
    idle(3);
    chk("mid_rst_no_err", 32'(n_err), 32'(exp_err));

    // Sync byte value as payload at word 3 lane 2
    pay[14] = SYNC;
    send_frame(8'h00, -1, 0);
    exp_done++;
    drain("sync_pay_good_drain");
    chk("sync_pay_done", 32'(n_done), 32'(exp_done));
    send(SYNC);
    for (int i = 0; i < int'(NB); i++) send(pay[i]);
    send(m_cs - SYNC);
    exp_err++;
    drain("sync_pay_bad_drain");
    chk("sync_pay_err", 32'(n_err), 32'(exp_err));
    chk("final_done", 32'(n_done), 32'(exp_done));

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
